stoch_signed_decoder: RTL and testbench

STOCH_SIGNED_DECODER -- requirements
Module: stoch_signed_decoder

---
 rtl/stoch_pkg.sv | 18 +
 rtl/stoch_signed_counter.sv | 26 ++
 rtl/stoch_signed_decoder.sv | 90 +++++++++
 tb/tb_stoch_signed_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// Shared types for the stochastic-computing blocks: decoder FSM states and accumulator sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stoch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        ACCUM  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Signed width that holds -window..+window.
    function automatic int acc_w(input int window);
        return $clog2(window) + 2;
    endfunction

endpackage

// File: rtl/stoch_signed_counter.sv
// Per-element signed up/down counter for a bipolar (p/m rail) stochastic stream.
// Latency: count reflects a sample one cycle after en is high with it.
// Backpressure: none; clr has priority over en.
module stoch_signed_counter #(
    parameter int ACC_W = 6
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    p,
    input  logic                    m,
    output logic signed [ACC_W-1:0] count
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (p ^ m)) begin
            count <= p ? count + ACC_W'(1) : count - ACC_W'(1);
        end
    end

endmodule

// File: rtl/stoch_signed_decoder.sv
// Decodes NUM_ELEMS signed stochastic streams by summing (p - m) over WINDOW cycles after SKIP warm-up cycles.
// Latency: result valid SKIP+WINDOW cycles after the start edge.
// Backpressure: result held in HOLD until out_ready; start is only accepted in IDLE or on the accepting HOLD cycle.
module stoch_signed_decoder
    import stoch_pkg::*;
#(
    parameter  int NUM_ELEMS = 9,
    parameter  int WINDOW    = 16,
    parameter  int SKIP      = 0,
    localparam int ACC_W     = acc_w(WINDOW)
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic                              start,
    input  logic [NUM_ELEMS-1:0]              x_p,
    input  logic [NUM_ELEMS-1:0]              x_m,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_ELEMS-1:0][ACC_W-1:0]   out_value
);

    localparam int CMAX  = (SKIP > WINDOW) ? SKIP : WINDOW;
    localparam int CNT_W = $clog2(CMAX + 1);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(WINDOW - 1);
    localparam state_t FIRST = (SKIP > 0) ? WARMUP : ACCUM;

    state_t                         state, state_nxt;
    logic [CNT_W-1:0]               cnt;
    logic                           clr;
    logic                           en;
    logic [NUM_ELEMS-1:0][ACC_W-1:0] count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FIRST;
            WARMUP:  if (cnt == WARM_LAST) state_nxt = ACCUM;
            ACCUM:   if (cnt == ACC_LAST) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = start ? FIRST : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == WARMUP) || (state == ACCUM);
        out_valid = (state == HOLD);
        en        = (state == ACCUM);
        clr       = start && ((state == IDLE) || ((state == HOLD) && out_ready));
    end

    // Phase counter restarts on every state change, so each phase counts from zero.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (state != state_nxt) begin
            cnt <= '0;
        end else if (busy) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_ELEMS; i++) begin : g_elem
        stoch_signed_counter #(
            .ACC_W (ACC_W)
        ) u_cnt (
            .CLK   (CLK),
            .nRST  (nRST),
            .clr   (clr),
            .en    (en),
            .p     (x_p[i]),
            .m     (x_m[i]),
            .count (count[i])
        );
    end

    always_comb begin
        out_value = out_valid ? count : '0;
    end

endmodule

// File: tb/tb_stoch_signed_decoder.sv
// Bench for stoch_signed_decoder: SKIP=0 and SKIP=3 instances against a transaction-level model.
module tb_stoch_signed_decoder;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int AW = 6;

    logic CLK = 1'b0;
    logic nRST;
    logic [N-1:0] x_p, x_m;
    logic start0, start3, rdy0, rdy3;
    logic busy0, busy3, vld0, vld3;
    logic [N-1:0][AW-1:0] ov0, ov3;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int n;
    bit tog;

    always #5 CLK = ~CLK;

    stoch_signed_decoder #(.NUM_ELEMS(N), .WINDOW(W), .SKIP(0)) dut0 (
        .CLK(CLK), .nRST(nRST), .start(start0), .x_p(x_p), .x_m(x_m),
        .busy(busy0), .out_valid(vld0), .out_ready(rdy0), .out_value(ov0)
    );

    stoch_signed_decoder #(.NUM_ELEMS(N), .WINDOW(W), .SKIP(3)) dut3 (
        .CLK(CLK), .nRST(nRST), .start(start3), .x_p(x_p), .x_m(x_m),
        .busy(busy3), .out_valid(vld3), .out_ready(rdy3), .out_value(ov3)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sval(input logic [AW-1:0] v);
        return int'($signed(v));
    endfunction

    // Model: a run starts on an accepted start, ages one per cycle, samples
    // during ages SKIP+1..SKIP+W, then holds its sum until handed off.
    bit m_act  [2];
    bit m_hold [2];
    int m_age  [2];
    int m_sum  [2][N];

    function automatic int skip_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int d = 0; d < 2; d++) begin
                m_act[d] = 1'b0; m_hold[d] = 1'b0; m_age[d] = 0;
                for (int e = 0; e < N; e++) m_sum[d][e] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit st, rd;
                st = (d == 0) ? start0 : start3;
                rd = (d == 0) ? rdy0 : rdy3;
                if (st && ((!m_act[d] && !m_hold[d]) || (m_hold[d] && rd))) begin
                    m_act[d] = 1'b1; m_hold[d] = 1'b0; m_age[d] = 0;
                    for (int e = 0; e < N; e++) m_sum[d][e] = 0;
                end else if (m_hold[d] && rd) begin
                    m_hold[d] = 1'b0;
                end else if (m_act[d]) begin
                    m_age[d]++;
                    if (m_age[d] > skip_of(d))
                        for (int e = 0; e < N; e++)
                            m_sum[d][e] += int'(x_p[e]) - int'(x_m[e]);
                    if (m_age[d] == skip_of(d) + W) begin
                        m_act[d] = 1'b0; m_hold[d] = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("busy0", int'(busy0), int'(m_act[0]));
            check("valid0", int'(vld0), int'(m_hold[0]));
            check("busy3", int'(busy3), int'(m_act[1]));
            check("valid3", int'(vld3), int'(m_hold[1]));
            for (int e = 0; e < N; e++) begin
                check("value0", sval(ov0[e]), m_hold[0] ? m_sum[0][e] : 0);
                check("value3", sval(ov3[e]), m_hold[1] ? m_sum[1][e] : 0);
            end
        end
    end

    task automatic wait_valid(input int d, output int cyc);
        cyc = 0;
        while (((d == 0) ? vld0 : vld3) == 1'b0 && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic reset_pulse();
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        check("rst_busy0", int'(busy0), 0);
        check("rst_valid0", int'(vld0), 0);
        check("rst_value0", int'(ov0), 0);
        check("rst_model", int'(m_act[0]), 0);
        @(negedge CLK);
        #1 nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b1; start0 = 0; start3 = 0; rdy0 = 0; rdy3 = 0; x_p = '0; x_m = '0;
        #1 nRST = 1'b0;
        #2;
        check("init_busy", int'(busy0), 0);
        check("init_valid", int'(vld0), 0);
        check("init_value", int'(ov0), 0);
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        cmp_en = 1'b1;
        @(negedge CLK);

        // Full-scale positive and negative streams.
        x_p = 2'b01; x_m = 2'b10; start0 = 1;
        @(negedge CLK);
        start0 = 0;
        wait_valid(0, n);
        check("s1_latency", n, 16);
        check("s1_e0", sval(ov0[0]), 16);
        check("s1_e1", sval(ov0[1]), -16);
        check("s1_model_e1", m_sum[0][1], -16);

        // Held result is stable under changing inputs and ignored start.
        repeat (5) begin
            x_p = 2'($urandom); x_m = 2'($urandom); start0 = 1'($urandom);
            @(negedge CLK);
            check("hold_valid", int'(vld0), 1);
            check("hold_e0", sval(ov0[0]), 16);
            check("hold_e1", sval(ov0[1]), -16);
        end
        start0 = 0; rdy0 = 1;
        @(negedge CLK);
        rdy0 = 0;
        check("ack_valid", int'(vld0), 0);
        check("ack_busy", int'(busy0), 0);

        // Half-density stream and cancelling rails.
        x_p = 2'b10; x_m = 2'b10; start0 = 1;
        @(negedge CLK);
        start0 = 0; tog = 1'b1; n = 0;
        while (!vld0 && n < 100) begin
            x_p[0] = tog; tog = !tog;
            @(negedge CLK);
            n++;
        end
        check("s2_latency", n, 16);
        check("s2_e0", sval(ov0[0]), 8);
        check("s2_e1", sval(ov0[1]), 0);
        check("s2_model_e0", m_sum[0][0], 8);

        // Back-to-back: accept and restart on the same cycle.
        x_p = 2'b11; x_m = 2'b00; start0 = 1; rdy0 = 1;
        @(negedge CLK);
        start0 = 0; rdy0 = 0;
        check("b2b_valid", int'(vld0), 0);
        check("b2b_busy", int'(busy0), 1);
        wait_valid(0, n);
        check("b2b_latency", n, 16);
        check("b2b_e0", sval(ov0[0]), 16);
        check("b2b_e1", sval(ov0[1]), 16);
        rdy0 = 1;
        @(negedge CLK);
        rdy0 = 0;

        // Reset in the middle of accumulation discards the partial sum.
        x_p = 2'b11; start0 = 1;
        @(negedge CLK);
        start0 = 0;
        repeat (6) @(negedge CLK);
        reset_pulse();
        repeat (3) begin
            @(negedge CLK);
            check("post_rst_valid", int'(vld0), 0);
            check("post_rst_busy", int'(busy0), 0);
        end
        x_p = 2'b11; x_m = 2'b00; start0 = 1;
        @(negedge CLK);
        start0 = 0;
        wait_valid(0, n);
        check("rst_rerun_latency", n, 16);
        check("rst_rerun_e0", sval(ov0[0]), 16);
        rdy0 = 1;
        @(negedge CLK);
        rdy0 = 0;

        // Warm-up samples must be discarded.
        x_p = 2'b11; x_m = 2'b00; start3 = 1;
        @(negedge CLK);
        start3 = 0; n = 0;
        while (!vld3 && n < 100) begin
            @(negedge CLK);
            n++;
            if (n == 3) x_p = 2'b00;
        end
        check("skip_latency", n, 19);
        check("skip_e0", sval(ov3[0]), 0);
        check("skip_e1", sval(ov3[1]), 0);
        rdy3 = 1;
        @(negedge CLK);
        rdy3 = 0;

        repeat (3000) begin
            x_p = 2'($urandom); x_m = 2'($urandom);
            start0 = ($urandom_range(3) == 0); start3 = ($urandom_range(3) == 0);
            rdy0 = ($urandom_range(2) != 0); rdy3 = ($urandom_range(2) != 0);
            if ($urandom_range(499) == 0) reset_pulse();
            @(negedge CLK);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
